// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory bus bridge.
// Command codes match the pipeline's BUS_* encoding.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return (f3[1:0] == 2'b01 && a[0]) ||
           (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a bus word and
// sign- or zero-extends it according to funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_BU:   data = {24'h0, b};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage bridge to a req/gnt/rvalid data bus with
// pipeline stall, lane steering, load extend and error reporting.
module dmem_bus_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid_inst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem2proc_data,
  output logic        dmem_stall,
  output logic        dmem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t state, state_n;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic          err_q;
  logic [CW-1:0] cnt;

  logic        access;
  logic        bad;
  logic        tmo;
  logic        cap;
  logic        err_set;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        ld_cap;
  logic        ld_zero;
  logic [31:0] ld_data;

  assign access = ex_mem_valid_inst &&
                  (proc2Dmem_command == BUS_LOAD ||
                   proc2Dmem_command == BUS_STORE);
  assign bad = !f3_legal(mem_funct3) ||
               misaligned(mem_funct3, proc2Dmem_addr[1:0]);
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);

  dmem_load_align u_align (
    .rdata  (bus_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_comb begin
    state_n    = state;
    cap        = 1'b0;
    err_set    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ld_cap     = 1'b0;
    ld_zero    = 1'b0;
    dmem_stall = 1'b0;
    bus_req    = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          dmem_stall = 1'b1;
          cap        = 1'b1;
          if (bad) begin
            err_set = 1'b1;
            state_n = DONE;
          end else begin
            cnt_clr = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        dmem_stall = 1'b1;
        bus_req    = 1'b1;
        if (bus_gnt) begin
          if (we_q) begin
            state_n = DONE;
          end else if (bus_rvalid) begin
            ld_cap  = 1'b1;
            state_n = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_n = WAIT;
          end
        end else if (tmo) begin
          err_set = 1'b1;
          ld_zero = !we_q;
          state_n = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT: begin
        dmem_stall = 1'b1;
        if (bus_rvalid) begin
          ld_cap  = 1'b1;
          state_n = DONE;
        end else if (tmo) begin
          err_set = 1'b1;
          ld_zero = 1'b1;
          state_n = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // err_q is only ever set on entry to DONE, so it doubles as the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      err_q         <= 1'b0;
      cnt           <= '0;
      mem2proc_data <= '0;
    end else begin
      err_q <= err_set;
      if (cap) begin
        addr_q  <= proc2Dmem_addr;
        f3_q    <= mem_funct3;
        we_q    <= proc2Dmem_command == BUS_STORE;
        be_q    <= be_gen(mem_funct3, proc2Dmem_addr[1:0]);
        wdata_q <= store_replicate(mem_funct3, proc2Dmem_data);
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (ld_cap) begin
        mem2proc_data <= ld_data;
      end else if (ld_zero) begin
        mem2proc_data <= '0;
      end
    end
  end

  assign dmem_err  = err_q;
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;
  assign bus_be    = bus_req ? be_q : '0;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Random + directed scoreboard bench for dmem_bus_bridge with a
// byte-array reference memory and a configurable bus slave.
module tb_dmem_bus_bridge;

  localparam int TMO = 8;
  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;

  logic        clk;
  logic        rst;
  logic        ex_mem_valid_inst;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem2proc_data;
  logic        dmem_stall;
  logic        dmem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  dmem_bus_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_mem_valid_inst (ex_mem_valid_inst),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2Dmem_data    (proc2Dmem_data),
    .mem_funct3        (mem_funct3),
    .mem2proc_data     (mem2proc_data),
    .dmem_stall        (dmem_stall),
    .dmem_err          (dmem_err),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_be            (bus_be),
    .bus_gnt           (bus_gnt),
    .bus_rvalid        (bus_rvalid),
    .bus_rdata         (bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  ref_b [0:63];
  logic [31:0] slv_w [0:15];
  logic [31:0] model_data;
  logic [2:0]  leg_f3 [0:4] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  int gd;
  int rd;
  bit no_gnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Bus slave: grants after gd request cycles, returns rdata rd cycles later
  bit          pend = 0;
  int          rv_left = 0;
  logic [3:0]  pidx;
  int          req_cnt = 0;

  initial begin
    bus_gnt = 0;
    bus_rvalid = 0;
    bus_rdata = 0;
  end

  always @(negedge clk) begin
    bus_t e;
    logic [3:0] idx;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = $urandom;
    if (pend) begin
      if (rv_left == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = slv_w[pidx];
        pend = 0;
      end else begin
        rv_left--;
      end
    end else if (bus_req) begin
      if (!no_gnt && req_cnt == gd) begin
        bus_gnt = 1'b1;
        req_cnt = 0;
        idx = bus_addr[5:2];
        if (bus_q.size() == 0) begin
          total_cnt++;
          $display("FAIL bus_unexpected: got req addr %h expected none",
                   bus_addr);
        end else begin
          e = bus_q.pop_front();
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_be", {28'h0, bus_be}, {28'h0, e.be});
          chk("bus_we", {31'h0, bus_we}, {31'h0, e.we});
          if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
        end
        if (bus_we) begin
          for (int j = 0; j < 4; j++)
            if (bus_be[j]) slv_w[idx][8*j +: 8] = bus_wdata[8*j +: 8];
        end else if (rd == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata  = slv_w[idx];
        end else begin
          pend    = 1;
          rv_left = rd - 1;
          pidx    = idx;
        end
      end else begin
        req_cnt++;
        if ($urandom_range(3) == 0) bus_rvalid = 1'b1;
      end
    end else begin
      req_cnt = 0;
      if ($urandom_range(3) == 0) bus_rvalid = 1'b1;
    end
  end

  // Monitor: completion is the first cycle an access sees stall low
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (ex_mem_valid_inst && (proc2Dmem_command == C_LOAD ||
                                proc2Dmem_command == C_STORE)) begin
        if (!dmem_stall) begin
          if (res_q.size() == 0) begin
            total_cnt++;
            $display("FAIL res_unexpected: got completion expected none");
          end else begin
            e = res_q.pop_front();
            chk("err", {31'h0, dmem_err}, {31'h0, e.err});
            chk("data", mem2proc_data, e.data);
          end
        end
      end else begin
        chk("idle_stall", {31'h0, dmem_stall}, 32'h0);
        chk("idle_err", {31'h0, dmem_err}, 32'h0);
      end
    end
  end

  task automatic issue(input logic v, input logic [1:0] cmd,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int g, input int r,
                       input bit tmo);
    int n;
    int nb;
    int off;
    int exp_stall;
    logic acc;
    logic legal;
    logic mis;
    logic [31:0] val;
    bus_t be_exp;
    acc = v && (cmd == C_LOAD || cmd == C_STORE);
    gd = g;
    rd = r;
    no_gnt = tmo;
    exp_stall = 0;
    if (acc) begin
      nb = 1 << f3[1:0];
      off = int'(a) - 32'h100;
      legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      mis = (a % nb) != 0;
      if (!legal || mis) begin
        exp_stall = 1;
        res_q.push_back('{1'b1, model_data});
      end else if (tmo) begin
        exp_stall = 1 + TMO;
        if (cmd == C_LOAD) model_data = 0;
        res_q.push_back('{1'b1, model_data});
      end else begin
        be_exp.addr = a & ~32'h3;
        be_exp.be = 0;
        for (int k = 0; k < nb; k++) be_exp.be[(a % 4) + k] = 1'b1;
        be_exp.we = cmd == C_STORE;
        for (int j = 0; j < 4; j++)
          be_exp.wdata[8*j +: 8] = d[8*(j % nb) +: 8];
        bus_q.push_back(be_exp);
        if (cmd == C_STORE) begin
          for (int k = 0; k < nb; k++) ref_b[off + k] = d[8*k +: 8];
          exp_stall = 2 + g;
        end else begin
          val = 0;
          for (int k = 0; k < nb; k++)
            val = val | (32'(ref_b[off + k]) << (8 * k));
          if (!f3[2] && nb < 4 && val[8*nb - 1])
            val = val | (32'hFFFF_FFFF << (8 * nb));
          model_data = val;
          exp_stall = 2 + g + r;
        end
        res_q.push_back('{1'b0, model_data});
      end
    end
    ex_mem_valid_inst = v;
    proc2Dmem_command = cmd;
    mem_funct3 = f3;
    proc2Dmem_addr = a;
    proc2Dmem_data = d;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!dmem_stall) break;
      n++;
    end
    chk("stall_cycles", n, exp_stall);
    @(posedge clk);
    #1;
    ex_mem_valid_inst = 1'b0;
    proc2Dmem_command = C_NONE;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  cmd;
    logic [2:0]  f3;
    logic [31:0] a;
    int          sel;
    for (int i = 0; i < 16; i++) begin
      slv_w[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = slv_w[i][8*k +: 8];
    end
    model_data = 0;
    gd = 0;
    rd = 0;
    no_gnt = 0;
    rst = 1'b1;
    ex_mem_valid_inst = 1'b0;
    proc2Dmem_command = C_NONE;
    proc2Dmem_addr = 0;
    proc2Dmem_data = 0;
    mem_funct3 = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_stall", {31'h0, dmem_stall}, 32'h0);
    chk("rst_err", {31'h0, dmem_err}, 32'h0);
    chk("rst_data", mem2proc_data, 32'h0);
    chk("rst_be", {28'h0, bus_be}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1, C_STORE, 3'b010, 32'h100, 32'h1234_5678, 0, 0, 0);
    issue(1, C_STORE, 3'b010, 32'h100, 32'h80FF_FFFF, 1, 0, 0);
    issue(1, C_LOAD,  3'b000, 32'h103, 32'h0, 3, 0, 0);
    chk("lb_value", mem2proc_data, 32'hFFFF_FF80);
    issue(1, C_STORE, 3'b001, 32'h102, 32'h0000_BEEF, 0, 0, 0);
    issue(1, C_LOAD,  3'b101, 32'h102, 32'h0, 1, 2, 0);
    chk("lhu_value", mem2proc_data, 32'h0000_BEEF);
    issue(1, C_STORE, 3'b001, 32'h106, 32'h7777_ABCD, 2, 0, 0);
    issue(1, C_LOAD,  3'b010, 32'h101, 32'h0, 0, 0, 0);
    chk("mis_hold", mem2proc_data, 32'h0000_BEEF);
    issue(1, C_LOAD,  3'b011, 32'h104, 32'h0, 0, 0, 0);
    issue(1, C_LOAD,  3'b000, 32'h104, 32'h0, 0, 0, 1);
    chk("tmo_zero", mem2proc_data, 32'h0);
    issue(1, C_LOAD,  3'b010, 32'h104, 32'h0, 0, 1, 0);

    // reset while the bridge waits for load data
    bus_q.push_back('{32'h108, 4'hF, 1'b0, 32'h0});
    gd = 0;
    rd = 3;
    ex_mem_valid_inst = 1'b1;
    proc2Dmem_command = C_LOAD;
    mem_funct3 = 3'b010;
    proc2Dmem_addr = 32'h108;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ex_mem_valid_inst = 1'b0;
    proc2Dmem_command = C_NONE;
    #1;
    chk("wrst_req", {31'h0, bus_req}, 32'h0);
    chk("wrst_stall", {31'h0, dmem_stall}, 32'h0);
    chk("wrst_data", mem2proc_data, 32'h0);
    model_data = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) issue(0, C_NONE, 3'b000, 32'h0, 32'h0, 0, 0, 0);
    chk("late_rvalid", mem2proc_data, 32'h0);
    issue(1, C_LOAD, 3'b010, 32'h108, 32'h0, 1, 1, 0);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(9);
      cmd = sel < 4 ? C_LOAD : (sel < 8 ? C_STORE : C_NONE);
      if ($urandom_range(9) == 0) f3 = 3'($urandom);
      else f3 = leg_f3[$urandom_range(4)];
      a = 32'h100 + $urandom_range(63);
      if ($urandom_range(3) != 0) a = a & ~((32'h1 << f3[1:0]) - 1);
      issue($urandom_range(7) != 0, cmd, f3, a, $urandom,
            $urandom_range(2), $urandom_range(3), 0);
    end

    repeat (4) @(negedge clk);
    chk("res_left", res_q.size(), 32'h0);
    chk("bus_left", bus_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
